// File: rtl/sauria_axi_pkg.sv
// Shared definitions for the SAURIA AXI4-lite configuration path: channel
// structs carried by sauria_axi4_lite_ifc, response codes and the master FSM
// state type.
package sauria_axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Channel payloads of sauria_axi4_lite_ifc; ready travels the other way.
  typedef struct packed {
    logic                  valid;
    logic [AXI_ADDR_W-1:0] addr;
    logic [2:0]            prot;
  } axi_aw_t;

  typedef struct packed {
    logic                  valid;
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
  } axi_w_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic                  valid;
    logic [AXI_ADDR_W-1:0] addr;
    logic [2:0]            prot;
  } axi_ar_t;

  typedef struct packed {
    logic                  valid;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
  } axi_r_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } cfg_state_e;

endpackage

// File: rtl/sauria_axi_timeout_ctr.sv
// Saturating wait-cycle counter. expired is high in the cycle where the
// counter sits at TIMEOUT_CYC-1 while enabled; TIMEOUT_CYC=0 never expires.
module sauria_axi_timeout_ctr #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [CNT_W-1:0] count_reg;

  // Clear has priority; otherwise count up while enabled and hold at the top.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= '0;
    end else if (en && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYC != 0) && en && (count_reg == CNT_LAST);

endmodule

// File: rtl/sauria_axi4_lite_cfg_master.sv
// Command-stream to AXI4-lite master bridge, one transaction in flight.
// The flattened AXI ports are views of sauria_axi4_lite_ifc channel structs.
module sauria_axi4_lite_cfg_master
  import sauria_axi_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_write,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  input  logic [DATA_W-1:0]   i_cmd_wdata,
  input  logic [DATA_W/8-1:0] i_cmd_wstrb,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic                o_rsp_write,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic [1:0]          o_rsp_resp,
  output logic                o_rsp_timeout,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [ADDR_W-1:0]   o_awaddr,
  output logic [2:0]          o_awprot,
  output logic                o_wvalid,
  input  logic                i_wready,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_wstrb,
  input  logic                i_bvalid,
  output logic                o_bready,
  input  logic [1:0]          i_bresp,
  output logic                o_arvalid,
  input  logic                i_arready,
  output logic [ADDR_W-1:0]   o_araddr,
  output logic [2:0]          o_arprot,
  input  logic                i_rvalid,
  output logic                o_rready,
  input  logic [DATA_W-1:0]   i_rdata,
  input  logic [1:0]          i_rresp
);

  cfg_state_e state_reg, state_next;

  axi_aw_t aw_reg;
  axi_w_t  w_reg;
  axi_ar_t ar_reg;
  axi_b_t  b_in;
  axi_r_t  r_in;

  logic                  aw_done_reg, w_done_reg, write_reg;
  logic [AXI_DATA_W-1:0] rsp_rdata_reg;
  logic [1:0]            rsp_resp_reg;
  logic                  rsp_timeout_reg;

  logic aw_hs, w_hs, ar_hs, wr_req_done;
  logic timer_clear, timer_en, timer_expired;

  assign b_in = '{valid: i_bvalid, resp: i_bresp};
  assign r_in = '{valid: i_rvalid, data: AXI_DATA_W'(i_rdata), resp: i_rresp};

  assign aw_hs = aw_reg.valid & i_awready;
  assign w_hs  = w_reg.valid & i_wready;
  assign ar_hs = ar_reg.valid & i_arready;
  // Both write beats finished, counting a handshake landing this cycle.
  assign wr_req_done = (aw_done_reg | aw_hs) & (w_done_reg | w_hs);

  // The timer runs only while waiting on the slave and restarts on every state change.
  assign timer_en    = (state_reg == ST_WR_REQ) || (state_reg == ST_WR_RESP) ||
                       (state_reg == ST_RD_REQ) || (state_reg == ST_RD_DATA);
  assign timer_clear = (state_next != state_reg);

  sauria_axi_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (i_clk),
    .srst   (i_rst),
    .clear  (timer_clear),
    .en     (timer_en),
    .expired(timer_expired)
  );

  // Next-state selection; an awaited handshake always beats a same-cycle expiry.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:    if (i_cmd_valid) state_next = i_cmd_write ? ST_WR_REQ : ST_RD_REQ;
      ST_WR_REQ:  if (wr_req_done) state_next = ST_WR_RESP;
                  else if (timer_expired) state_next = ST_RSP;
      ST_WR_RESP: if (b_in.valid || timer_expired) state_next = ST_RSP;
      ST_RD_REQ:  if (ar_hs) state_next = ST_RD_DATA;
                  else if (timer_expired) state_next = ST_RSP;
      ST_RD_DATA: if (r_in.valid || timer_expired) state_next = ST_RSP;
      ST_RSP:     if (i_rsp_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Channel valids, payload capture and response fields.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg       <= ST_IDLE;
      aw_reg          <= '0;
      w_reg           <= '0;
      ar_reg          <= '0;
      aw_done_reg     <= 1'b0;
      w_done_reg      <= 1'b0;
      write_reg       <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_resp_reg    <= AXI_RESP_OKAY;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      unique case (state_reg)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            write_reg    <= i_cmd_write;
            aw_reg.addr  <= AXI_ADDR_W'(i_cmd_addr);
            ar_reg.addr  <= AXI_ADDR_W'(i_cmd_addr);
            w_reg.data   <= AXI_DATA_W'(i_cmd_wdata);
            w_reg.strb   <= AXI_STRB_W'(i_cmd_wstrb);
            aw_reg.valid <= i_cmd_write;
            w_reg.valid  <= i_cmd_write;
            ar_reg.valid <= ~i_cmd_write;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
          end
        end
        ST_WR_REQ: begin
          if (aw_hs) begin
            aw_reg.valid <= 1'b0;
            aw_done_reg  <= 1'b1;
          end
          if (w_hs) begin
            w_reg.valid <= 1'b0;
            w_done_reg  <= 1'b1;
          end
          if (!wr_req_done && timer_expired) begin
            aw_reg.valid    <= 1'b0;
            w_reg.valid     <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= AXI_RESP_SLVERR;
            rsp_timeout_reg <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (b_in.valid) begin
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= b_in.resp;
            rsp_timeout_reg <= 1'b0;
          end else if (timer_expired) begin
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= AXI_RESP_SLVERR;
            rsp_timeout_reg <= 1'b1;
          end
        end
        ST_RD_REQ: begin
          if (ar_hs) begin
            ar_reg.valid <= 1'b0;
          end else if (timer_expired) begin
            ar_reg.valid    <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= AXI_RESP_SLVERR;
            rsp_timeout_reg <= 1'b1;
          end
        end
        ST_RD_DATA: begin
          if (r_in.valid) begin
            rsp_rdata_reg   <= r_in.data;
            rsp_resp_reg    <= r_in.resp;
            rsp_timeout_reg <= 1'b0;
          end else if (timer_expired) begin
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= AXI_RESP_SLVERR;
            rsp_timeout_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_ready   = (state_reg == ST_IDLE);
  assign o_rsp_valid   = (state_reg == ST_RSP);
  assign o_bready      = (state_reg == ST_WR_RESP);
  assign o_rready      = (state_reg == ST_RD_DATA);
  assign o_rsp_write   = write_reg;
  assign o_rsp_rdata   = DATA_W'(rsp_rdata_reg);
  assign o_rsp_resp    = rsp_resp_reg;
  assign o_rsp_timeout = rsp_timeout_reg;

  assign o_awvalid = aw_reg.valid;
  assign o_awaddr  = ADDR_W'(aw_reg.addr);
  assign o_awprot  = aw_reg.prot;
  assign o_wvalid  = w_reg.valid;
  assign o_wdata   = DATA_W'(w_reg.data);
  assign o_wstrb   = (DATA_W/8)'(w_reg.strb);
  assign o_arvalid = ar_reg.valid;
  assign o_araddr  = ADDR_W'(ar_reg.addr);
  assign o_arprot  = ar_reg.prot;

endmodule

// File: tb/tb_sauria_axi4_lite_cfg_master.sv
// Scoreboard bench: a behavioural register-file model predicts each response
// at issue time; a negedge monitor pops and compares when responses appear.
module tb_sauria_axi4_lite_cfg_master;

  localparam int TO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [31:0] i_cmd_addr, i_cmd_wdata;
  logic [3:0]  i_cmd_wstrb;
  logic        o_rsp_valid, i_rsp_ready, o_rsp_write, o_rsp_timeout;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
  logic        o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic [31:0] o_awaddr, o_wdata, o_araddr, i_rdata;
  logic [2:0]  o_awprot, o_arprot;
  logic [3:0]  o_wstrb;
  logic [1:0]  i_bresp, i_rresp;
  logic        o_arvalid, i_arready, i_rvalid, o_rready;

  always #5 i_clk = ~i_clk;

  sauria_axi4_lite_cfg_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr), .o_awprot(o_awprot),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr), .o_arprot(o_arprot),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp)
  );

  // hang: 0 none, 1 address channel never ready (AW or AR), 2 B/R never returned
  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly, hang;
  } cmd_t;

  typedef struct {
    bit          write;
    logic [31:0] rdata;
    logic [1:0]  resp;
    bit          timeout;
    int          awc, wc, arc;
  } exp_t;

  exp_t        exp_q[$];
  cmd_t        cur;
  logic [31:0] model_mem[32];
  logic [31:0] slv_mem[32];
  logic [31:0] slv_aw_addr, slv_wdata, slv_ar_addr;
  logic [3:0]  slv_wstrb;
  int          total = 0, bad = 0, rsp_stall = 0;
  int          awc = 0, wc = 0, arc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: slave is a 32-word register file; bit 6 of the address selects SLVERR.
  function automatic exp_t predict(input cmd_t c);
    exp_t e;
    int   idx = int'(c.addr[6:2]);
    e.write = c.write; e.rdata = '0; e.resp = 2'b00; e.timeout = 1'b0;
    e.awc = 0; e.wc = 0; e.arc = 0;
    if (c.write) begin
      e.awc = (c.hang == 1) ? 0 : 1;
      e.wc  = 1;
    end else begin
      e.arc = (c.hang == 1) ? 0 : 1;
    end
    if (c.hang != 0) begin
      e.timeout = 1'b1;
      e.resp    = 2'b10;
    end else begin
      e.resp = c.addr[6] ? 2'b10 : 2'b00;
      if (c.write) begin
        for (int b = 0; b < 4; b++)
          if (c.wstrb[b]) model_mem[idx][8*b +: 8] = c.wdata[8*b +: 8];
      end else begin
        e.rdata = model_mem[idx];
      end
    end
    return e;
  endfunction

  // ---------------- slave channel models (drive at posedge+1) ----------------
  initial begin
    int aw_wait = 0;
    i_awready = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      i_awready = 1'b0;
      if (o_awvalid && !(cur.write && cur.hang == 1)) begin
        if (aw_wait >= cur.aw_dly) begin i_awready = 1'b1; aw_wait = 0; end
        else aw_wait++;
      end else aw_wait = 0;
    end
  end

  initial begin
    int w_wait = 0;
    i_wready = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      i_wready = 1'b0;
      if (o_wvalid) begin
        if (w_wait >= cur.w_dly) begin i_wready = 1'b1; w_wait = 0; end
        else w_wait++;
      end else w_wait = 0;
    end
  end

  initial begin
    int b_wait = 0;
    for (int i = 0; i < 32; i++) slv_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    i_bvalid = 1'b0; i_bresp = 2'b00;
    forever begin
      @(posedge i_clk); #1;
      i_bvalid = 1'b0;
      if (o_bready) begin
        if (cur.hang != 2) begin
          if (b_wait >= cur.b_dly) begin
            for (int b = 0; b < 4; b++)
              if (slv_wstrb[b]) slv_mem[slv_aw_addr[6:2]][8*b +: 8] = slv_wdata[8*b +: 8];
            i_bvalid = 1'b1;
            i_bresp  = slv_aw_addr[6] ? 2'b10 : 2'b00;
            b_wait   = 0;
          end else b_wait++;
        end
      end else begin
        b_wait   = 0;
        i_bvalid = ($urandom_range(0, 7) == 0);
        i_bresp  = 2'b11;
      end
    end
  end

  initial begin
    int ar_wait = 0;
    i_arready = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      i_arready = 1'b0;
      if (o_arvalid && !(!cur.write && cur.hang == 1)) begin
        if (ar_wait >= cur.ar_dly) begin i_arready = 1'b1; ar_wait = 0; end
        else ar_wait++;
      end else ar_wait = 0;
    end
  end

  initial begin
    int r_wait = 0;
    i_rvalid = 1'b0; i_rdata = '0; i_rresp = 2'b00;
    forever begin
      @(posedge i_clk); #1;
      i_rvalid = 1'b0;
      if (o_rready) begin
        if (cur.hang != 2) begin
          if (r_wait >= cur.r_dly) begin
            i_rvalid = 1'b1;
            i_rdata  = slv_mem[slv_ar_addr[6:2]];
            i_rresp  = slv_ar_addr[6] ? 2'b10 : 2'b00;
            r_wait   = 0;
          end else r_wait++;
        end
      end else begin
        r_wait   = 0;
        i_rvalid = ($urandom_range(0, 7) == 0);
        i_rdata  = $urandom;
        i_rresp  = 2'b11;
      end
    end
  end

  // Response back-pressure: forced stall cycles first, then random.
  initial begin
    i_rsp_ready = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      if (o_rsp_valid && rsp_stall > 0) begin
        i_rsp_ready = 1'b0;
        rsp_stall--;
      end else begin
        i_rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- monitor / scoreboard (negedge) ----------------
  initial begin
    logic        pv_aw = 0, pr_aw = 0, pv_w = 0, pr_w = 0, pv_ar = 0, pr_ar = 0;
    logic        pv_rsp = 0, pr_rsp = 0, post_rsp = 0;
    logic [31:0] p_awaddr = 0, p_araddr = 0;
    logic [35:0] p_w = 0;
    logic [35:0] p_rsp = 0;
    exp_t        e;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        pv_aw = 0; pv_w = 0; pv_ar = 0; pv_rsp = 0; post_rsp = 0;
        awc = 0; wc = 0; arc = 0;
      end else begin
        if (o_awvalid && i_awready) begin
          awc++;
          check("awaddr", o_awaddr, cur.addr);
          check("awprot", o_awprot, 3'b000);
          slv_aw_addr = o_awaddr;
        end
        if (o_wvalid && i_wready) begin
          wc++;
          check("wdata", {o_wstrb, o_wdata}, {cur.wstrb, cur.wdata});
          slv_wdata = o_wdata; slv_wstrb = o_wstrb;
        end
        if (o_arvalid && i_arready) begin
          arc++;
          check("araddr", o_araddr, cur.addr);
          check("arprot", o_arprot, 3'b000);
          slv_ar_addr = o_araddr;
        end
        if (pv_aw && !pr_aw && !o_rsp_valid) check("aw_hold", {o_awvalid, o_awaddr}, {1'b1, p_awaddr});
        if (pv_w && !pr_w && !o_rsp_valid)   check("w_hold", {o_wvalid, o_wstrb, o_wdata}, {1'b1, p_w});
        if (pv_ar && !pr_ar && !o_rsp_valid) check("ar_hold", {o_arvalid, o_araddr}, {1'b1, p_araddr});
        if (pv_rsp && !pr_rsp)
          check("rsp_hold", {o_rsp_valid, o_rsp_write, o_rsp_timeout, o_rsp_resp, o_rsp_rdata},
                {1'b1, p_rsp[35], p_rsp[34], p_rsp[33:32], p_rsp[31:0]});
        if (post_rsp) begin
          check("cmd_ready_after_rsp", {o_cmd_ready, o_rsp_valid}, 2'b10);
          post_rsp = 0;
        end
        if (o_rsp_valid) check("cmd_ready_in_rsp", o_cmd_ready, 1'b0);
        if (o_bready || o_rready)
          check("ready_exclusive", {o_awvalid, o_wvalid, o_arvalid, o_bready & o_rready}, 4'b0);
        if (o_rsp_valid && i_rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_write", o_rsp_write, e.write);
            check("rsp_rdata", o_rsp_rdata, e.rdata);
            check("rsp_resp", o_rsp_resp, e.resp);
            check("rsp_timeout", o_rsp_timeout, e.timeout);
            check("beats", {awc[7:0], wc[7:0], arc[7:0]}, {e.awc[7:0], e.wc[7:0], e.arc[7:0]});
            $display("rsp write=%0d rdata=%08h resp=%0d timeout=%0d", o_rsp_write, o_rsp_rdata,
                     o_rsp_resp, o_rsp_timeout);
          end
          awc = 0; wc = 0; arc = 0;
          post_rsp = 1;
        end
        pv_aw = o_awvalid; pr_aw = i_awready; p_awaddr = o_awaddr;
        pv_w = o_wvalid; pr_w = i_wready; p_w = {o_wstrb, o_wdata};
        pv_ar = o_arvalid; pr_ar = i_arready; p_araddr = o_araddr;
        pv_rsp = o_rsp_valid; pr_rsp = i_rsp_ready;
        p_rsp = {o_rsp_write, o_rsp_timeout, o_rsp_resp, o_rsp_rdata};
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input cmd_t c, input bit push);
    int budget = 0;
    if (push) exp_q.push_back(predict(c));
    i_cmd_valid = 1'b1; i_cmd_write = c.write; i_cmd_addr = c.addr;
    i_cmd_wdata = c.wdata; i_cmd_wstrb = c.wstrb;
    while (!o_cmd_ready && budget < 200) begin
      @(posedge i_clk); #1;
      budget++;
    end
    if (!o_cmd_ready) check("cmd_accept_timeout", budget, 0);
    @(posedge i_clk);
    cur = c;
    #1;
    i_cmd_valid = 1'b0;
  endtask

  function automatic cmd_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int awd, input int wd, input int bd,
                              input int ard, input int rd, input int h);
    cmd_t c;
    c.write = wr; c.addr = a; c.wdata = d; c.wstrb = s;
    c.aw_dly = awd; c.w_dly = wd; c.b_dly = bd; c.ar_dly = ard; c.r_dly = rd; c.hang = h;
    return c;
  endfunction

  task automatic drain();
    int budget = 0;
    while ((exp_q.size() != 0 || !o_cmd_ready) && budget < 500) begin
      @(posedge i_clk); #1;
      budget++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    int   cnt;
    logic [31:0] a;
    for (int i = 0; i < 32; i++) model_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0;
    i_cmd_addr = '0; i_cmd_wdata = '0; i_cmd_wstrb = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rsp_valid}, 6'b0);
    check("reset_data", {o_awaddr, o_wdata, o_wstrb, o_araddr}, 64'h0);
    check("reset_rsp", {o_rsp_write, o_rsp_rdata, o_rsp_resp, o_rsp_timeout}, 36'h0);
    check("reset_cmd_ready", o_cmd_ready, 1'b1);
    i_rst = 1'b0;

    $display("txn write 0x10 DEADBEEF, immediate ready");
    issue(mk(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 0, 0, 0), 1);
    $display("txn write 0x24, wready 3 cycles before awready");
    issue(mk(1, 32'h24, 32'h1234_5678, 4'hF, 3, 0, 0, 0, 0, 0), 1);
    @(posedge i_clk); #1;
    check("w_dropped_aw_held", {o_awvalid, o_wvalid}, 2'b10);
    $display("txn read 0x24, rdata after 5 cycles");
    issue(mk(0, 32'h24, 0, 0, 0, 0, 0, 0, 5, 0), 1);
    $display("txn read with arready never asserted");
    issue(mk(0, 32'h30, 0, 0, 0, 0, 0, 0, 0, 1), 1);
    cnt = 0;
    while (o_arvalid && cnt < 50) begin cnt++; @(posedge i_clk); #1; end
    check("arvalid_cycles", cnt, TO);
    $display("txn response stalled 4 cycles with next command pending");
    rsp_stall = 4;
    issue(mk(1, 32'h44, 32'hCAFE_F00D, 4'b0101, 1, 2, 0, 0, 0, 0), 1);
    issue(mk(0, 32'h44, 0, 0, 0, 0, 0, 2, 1, 0), 1);
    $display("txn boundary delays: handshake on expiry cycle");
    issue(mk(1, 32'h08, 32'h0BAD_CAFE, 4'hF, TO-1, TO-1, TO-1, 0, 0, 0), 1);
    issue(mk(0, 32'h08, 0, 0, 0, 0, 0, TO-1, TO-1, 0), 1);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      a[1:0] = 2'b00;
      c = mk($urandom_range(0, 1), a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, TO-1), $urandom_range(0, TO-1), $urandom_range(0, TO-1),
             $urandom_range(0, TO-1), $urandom_range(0, TO-1),
             ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0);
      $display("txn rand write=%0d addr=%08h hang=%0d", c.write, c.addr, c.hang);
      issue(c, 1);
    end
    drain();

    $display("txn reset during WR_RESP");
    issue(mk(1, 32'h50, 32'h5555_AAAA, 4'hF, 0, 0, 0, 0, 0, 2), 0);
    cnt = 0;
    while (!o_bready && cnt < 50) begin cnt++; @(posedge i_clk); #1; end
    check("reached_wr_resp", o_bready, 1'b1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("rst_mid_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rsp_valid}, 6'b0);
    check("rst_mid_cmd_ready", o_cmd_ready, 1'b1);
    i_rst = 1'b0;
    $display("txn read 0x50 after abandoned write");
    issue(mk(0, 32'h50, 0, 0, 0, 0, 0, 1, 1, 0), 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
